sistema_pio_in: RTL and testbench



---
 rtl/sistema_pio_in.sv | 107 ++++++++++
 tb/tb_sistema_pio_in.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sistema_pio_in.sv
// Avalon-MM input PIO: synchronizes and optionally debounces an external bus,
// latches edges into a sticky capture register and raises a masked level irq.
module sistema_pio_in #(
  parameter int unsigned      WIDTH           = 3,
  parameter int unsigned      DEBOUNCE_CYCLES = 0,
  parameter int unsigned      EDGE_TYPE       = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (DEBOUNCE_CYCLES > 0) ? CW'(DEBOUNCE_CYCLES - 1) : '0;

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic             irq_q, irq_d;

  logic             wr_en;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] clr;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and infers a latch.
    sync1_d = in_port;
    sync2_d = sync1_q;
    prev_d  = deb_q;
    deb_d   = deb_q;

    // A bit only moves once sync2 has disagreed with it for DEBOUNCE_CYCLES samples in a row.
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (DEBOUNCE_CYCLES == 0) begin
        deb_d[i] = sync2_q[i];
      end else if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) deb_d[i] = sync2_q[i];
        else                      cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end

    case (EDGE_TYPE)
      0:       edges = deb_q & ~prev_q;
      1:       edges = ~deb_q & prev_q;
      default: edges = deb_q ^ prev_q;
    endcase

    wr_en  = chipselect & ~write_n;
    clr    = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    cap_d  = (cap_q & ~clr) | edges;
    mask_d = (wr_en && address == 2'd1) ? writedata[WIDTH-1:0] : mask_q;
    irq_d  = |(cap_q & mask_q);
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = deb_q;
      2'd1:    readdata[WIDTH-1:0] = mask_q;
      2'd3:    readdata[WIDTH-1:0] = cap_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= RESET_VALUE;
      sync2_q <= RESET_VALUE;
      deb_q   <= RESET_VALUE;
      prev_q  <= RESET_VALUE;
      cap_q   <= '0;
      mask_q  <= '0;
      // NOTE: the per-bit counter array is tiny and must restart from zero, so it is reset like plain flops.
      cnt_q   <= '{default: '0};
      irq_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates, so every flop samples the values from before this edge.
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      prev_q  <= prev_d;
      cap_q   <= cap_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_sistema_pio_in.sv
// Bench for sistema_pio_in: four parameter variants on a shared bus, a vector
// table, hand-written corner sequences and a random run against a history model.
module tb_sistema_pio_in;

  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [2:0]  in_port;
  logic [31:0] rd [NI];
  logic        irq_o [NI];

  always #5 clk = ~clk;

  sistema_pio_in #(.WIDTH(3), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0), .RESET_VALUE(3'b000)) u0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd[0]), .irq(irq_o[0]));
  sistema_pio_in #(.WIDTH(3), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0), .RESET_VALUE(3'b000)) u1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd[1]), .irq(irq_o[1]));
  sistema_pio_in #(.WIDTH(3), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2), .RESET_VALUE(3'b000)) u2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd[2]), .irq(irq_o[2]));
  sistema_pio_in #(.WIDTH(3), .DEBOUNCE_CYCLES(2), .EDGE_TYPE(1), .RESET_VALUE(3'b110)) u3 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd[3]), .irq(irq_o[3]));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-instance history of raw input samples; a debounced bit
  // flips when the last N samples seen at the second synchronizer stage all disagree.
  int         db_n [NI] = '{0, 4, 0, 2};
  int         et   [NI] = '{0, 0, 2, 1};
  logic [2:0] rv   [NI] = '{3'b000, 3'b000, 3'b000, 3'b110};
  logic [2:0] hist [NI][8];
  logic [2:0] m_deb [NI], m_prev [NI], m_cap [NI], m_mask [NI];
  logic       m_irq [NI];

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      for (int j = 0; j < 8; j++) hist[k][j] = rv[k];
      m_deb[k]  = rv[k];
      m_prev[k] = rv[k];
      m_cap[k]  = 3'b000;
      m_mask[k] = 3'b000;
      m_irq[k]  = 1'b0;
    end
  endtask

  function automatic logic [31:0] model_read(input int k);
    case (address)
      2'd0:    return 32'(m_deb[k]);
      2'd1:    return 32'(m_mask[k]);
      2'd3:    return 32'(m_cap[k]);
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    logic       wr;
    logic [2:0] nd, ev, clr;
    bit         stable;
    wr = chipselect && !write_n;
    for (int k = 0; k < NI; k++) begin
      for (int j = 7; j > 0; j--) hist[k][j] = hist[k][j-1];
      hist[k][0] = in_port;
      nd = m_deb[k];
      for (int i = 0; i < 3; i++) begin
        if (db_n[k] == 0) begin
          nd[i] = hist[k][2][i];
        end else begin
          stable = 1'b1;
          for (int j = 0; j < db_n[k]; j++)
            if (hist[k][2+j][i] == m_deb[k][i]) stable = 1'b0;
          if (stable) nd[i] = ~m_deb[k][i];
        end
      end
      case (et[k])
        0:       ev = m_deb[k] & ~m_prev[k];
        1:       ev = ~m_deb[k] & m_prev[k];
        default: ev = m_deb[k] ^ m_prev[k];
      endcase
      clr       = (wr && address == 2'd3) ? writedata[2:0] : 3'b000;
      m_irq[k]  = |(m_cap[k] & m_mask[k]);
      m_cap[k]  = (m_cap[k] & ~clr) | ev;
      if (wr && address == 2'd1) m_mask[k] = writedata[2:0];
      m_prev[k] = m_deb[k];
      m_deb[k]  = nd;
    end
  endtask

  task automatic set_reset(input logic v);
    reset = v;
    if (v) model_reset();
  endtask

  task automatic drive(input logic [1:0] a, input logic cs, input logic wr,
                       input logic [31:0] wd, input logic [2:0] ip);
    address    = a;
    chipselect = cs;
    write_n    = ~wr;
    writedata  = wd;
    in_port    = ip;
    #1;
  endtask

  // Compare every instance against the model, then advance one clock.
  task automatic step();
    for (int k = 0; k < NI; k++) begin
      check($sformatf("model u%0d rd a%0d", k, address), rd[k], model_read(k));
      check($sformatf("model u%0d irq", k), 32'(irq_o[k]), 32'(m_irq[k]));
    end
    if (reset) model_reset();
    else       model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [1:0] a, input logic [2:0] ip);
    repeat (n) begin
      drive(a, 1'b1, 1'b0, 32'h0, ip);
      step();
    end
  endtask

  typedef struct {
    logic [1:0]  a;
    logic        cs;
    logic        wr;
    logic [31:0] wd;
    logic [2:0]  ip;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl [35];

  initial begin
    logic [2:0] ip;
    int         rst_left;

    tbl = '{
      '{2'd0, 1'b1, 1'b0, 32'h0, 3'd5, 32'h0, 1'b0},
      '{2'd0, 1'b1, 1'b0, 32'h0, 3'd5, 32'h0, 1'b0},
      '{2'd0, 1'b1, 1'b0, 32'h0, 3'd5, 32'h0, 1'b0},
      '{2'd0, 1'b1, 1'b0, 32'h0, 3'd5, 32'h5, 1'b0},
      '{2'd3, 1'b1, 1'b0, 32'h0, 3'd5, 32'h5, 1'b0},
      '{2'd1, 1'b1, 1'b1, 32'h1, 3'd5, 32'h0, 1'b0},
      '{2'd3, 1'b1, 1'b1, 32'h7, 3'd5, 32'h5, 1'b0},
      '{2'd1, 1'b1, 1'b0, 32'h0, 3'd5, 32'h1, 1'b1},
      '{2'd3, 1'b1, 1'b0, 32'h0, 3'd4, 32'h0, 1'b0},
      '{2'd0, 1'b1, 1'b0, 32'h0, 3'd4, 32'h5, 1'b0},
      '{2'd0, 1'b1, 1'b0, 32'h0, 3'd4, 32'h5, 1'b0},
      '{2'd0, 1'b1, 1'b0, 32'h0, 3'd4, 32'h4, 1'b0},
      '{2'd3, 1'b1, 1'b0, 32'h0, 3'd5, 32'h0, 1'b0},
      '{2'd0, 1'b1, 1'b0, 32'h0, 3'd5, 32'h4, 1'b0},
      '{2'd0, 1'b1, 1'b0, 32'h0, 3'd5, 32'h4, 1'b0},
      '{2'd0, 1'b1, 1'b0, 32'h0, 3'd5, 32'h5, 1'b0},
      '{2'd3, 1'b1, 1'b0, 32'h0, 3'd5, 32'h1, 1'b0},
      '{2'd3, 1'b1, 1'b1, 32'h1, 3'd5, 32'h1, 1'b1},
      '{2'd3, 1'b1, 1'b0, 32'h0, 3'd4, 32'h0, 1'b1},
      '{2'd3, 1'b1, 1'b0, 32'h0, 3'd5, 32'h0, 1'b0},
      '{2'd3, 1'b1, 1'b0, 32'h0, 3'd4, 32'h0, 1'b0},
      '{2'd0, 1'b1, 1'b0, 32'h0, 3'd5, 32'h4, 1'b0},
      '{2'd0, 1'b1, 1'b0, 32'h0, 3'd5, 32'h5, 1'b0},
      '{2'd3, 1'b1, 1'b0, 32'h0, 3'd5, 32'h1, 1'b0},
      '{2'd3, 1'b1, 1'b1, 32'h1, 3'd5, 32'h1, 1'b1},
      '{2'd3, 1'b1, 1'b0, 32'h0, 3'd5, 32'h1, 1'b1},
      '{2'd1, 1'b1, 1'b1, 32'h0, 3'd5, 32'h1, 1'b1},
      '{2'd3, 1'b1, 1'b0, 32'h0, 3'd5, 32'h1, 1'b1},
      '{2'd3, 1'b1, 1'b0, 32'h0, 3'd5, 32'h1, 1'b0},
      '{2'd2, 1'b1, 1'b0, 32'h0, 3'd5, 32'h0, 1'b0},
      '{2'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 3'd5, 32'h5, 1'b0},
      '{2'd1, 1'b1, 1'b1, 32'hFFFF_FFFA, 3'd5, 32'h0, 1'b0},
      '{2'd1, 1'b1, 1'b0, 32'h0, 3'd5, 32'h2, 1'b0},
      '{2'd1, 1'b0, 1'b1, 32'h7, 3'd5, 32'h2, 1'b0},
      '{2'd1, 1'b1, 1'b0, 32'h0, 3'd5, 32'h2, 1'b0}
    };

    // Reset held with in_port = 101 already present.
    set_reset(1'b1);
    drive(2'd0, 1'b0, 1'b0, 32'h0, 3'd5);
    @(negedge clk);
    repeat (3) step();
    set_reset(1'b0);

    for (int i = 0; i < 35; i++) begin
      drive(tbl[i].a, tbl[i].cs, tbl[i].wr, tbl[i].wd, tbl[i].ip);
      check($sformatf("tbl[%0d] rd", i), rd[0], tbl[i].exp_rd);
      check($sformatf("tbl[%0d] irq", i), 32'(irq_o[0]), 32'(tbl[i].exp_irq));
      step();
    end

    // Debouncer: a 3-cycle glitch is rejected, a 6-cycle pulse is accepted 4 cycles after sync2.
    idle(8, 2'd0, 3'b000);
    for (int t = 0; t < 13; t++) begin
      drive(2'd0, 1'b1, 1'b0, 32'h0, (t < 3) ? 3'b010 : 3'b000);
      check($sformatf("glitch t%0d u1 bit1", t), rd[1] & 32'h2, 32'h0);
      step();
    end
    drive(2'd3, 1'b1, 1'b0, 32'h0, 3'b000);
    check("glitch u1 no edge", rd[1] & 32'h2, 32'h0);
    step();
    for (int t = 0; t < 8; t++) begin
      drive((t < 7) ? 2'd0 : 2'd3, 1'b1, 1'b0, 32'h0, (t < 6) ? 3'b010 : 3'b000);
      if (t == 5) check("debounce u1 not yet", rd[1] & 32'h2, 32'h0);
      if (t == 6) check("debounce u1 accepted", rd[1] & 32'h2, 32'h2);
      if (t == 7) check("debounce u1 edge", rd[1] & 32'h2, 32'h2);
      step();
    end

    // Any-edge: two separate captures on bit 2, then masking off with a capture pending.
    idle(6, 2'd0, 3'b000);
    drive(2'd1, 1'b1, 1'b1, 32'h7, 3'b000); step();
    drive(2'd3, 1'b1, 1'b1, 32'h7, 3'b000); step();
    idle(2, 2'd3, 3'b000);
    for (int t = 0; t < 16; t++) begin
      ip = (t < 8) ? 3'b100 : 3'b000;
      if (t == 5)       drive(2'd3, 1'b1, 1'b1, 32'h4, ip);
      else if (t == 13) drive(2'd1, 1'b1, 1'b1, 32'h0, ip);
      else              drive(2'd3, 1'b1, 1'b0, 32'h0, ip);
      case (t)
        4:  begin check("any rise cap", rd[2], 32'h4); check("any rise irq lag", 32'(irq_o[2]), 32'h0); end
        5:  begin check("any rise irq", 32'(irq_o[2]), 32'h1); check("any cap before clr", rd[2], 32'h4); end
        6:  begin check("any clr cap", rd[2], 32'h0); check("any clr irq lag", 32'(irq_o[2]), 32'h1); end
        7:  check("any clr irq", 32'(irq_o[2]), 32'h0);
        12: check("any fall cap", rd[2], 32'h4);
        13: begin check("any fall irq", 32'(irq_o[2]), 32'h1); check("mask before", rd[2], 32'h7); end
        14: begin check("mask0 irq lag", 32'(irq_o[2]), 32'h1); check("mask0 cap kept", rd[2], 32'h4); end
        15: begin check("mask0 irq", 32'(irq_o[2]), 32'h0); check("mask0 cap still", rd[2], 32'h4); end
        default: ;
      endcase
      step();
    end

    // Asynchronous reset with irq high and a debounce count running.
    drive(2'd1, 1'b1, 1'b1, 32'h7, 3'b000); step();
    idle(2, 2'd0, 3'b000);
    idle(3, 2'd0, 3'b010);
    drive(2'd0, 1'b1, 1'b0, 32'h0, 3'b010);
    check("pre-reset u2 irq", 32'(irq_o[2]), 32'h1);
    #2;
    set_reset(1'b1);
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("async rst u%0d irq", k), 32'(irq_o[k]), 32'h0);
      check($sformatf("async rst u%0d deb", k), rd[k], 32'(rv[k]));
    end
    step();
    drive(2'd0, 1'b1, 1'b0, 32'h0, 3'b000);
    step();
    set_reset(1'b0);
    for (int t = 0; t < 8; t++) begin
      drive(2'd3, 1'b1, 1'b0, 32'h0, 3'b000);
      for (int k = 0; k < 3; k++) begin
        check($sformatf("post rst u%0d cap t%0d", k, t), rd[k], 32'h0);
        check($sformatf("post rst u%0d irq t%0d", k, t), 32'(irq_o[k]), 32'h0);
      end
      step();
    end
    drive(2'd1, 1'b1, 1'b0, 32'h0, 3'b000);
    for (int k = 0; k < 3; k++) check($sformatf("post rst u%0d mask", k), rd[k], 32'h0);
    step();

    // Input already equal to a non-zero reset value must not produce an edge.
    set_reset(1'b1);
    drive(2'd0, 1'b1, 1'b0, 32'h0, 3'b110);
    step(); step();
    set_reset(1'b0);
    for (int t = 0; t < 8; t++) begin
      drive(2'd3, 1'b1, 1'b0, 32'h0, 3'b110);
      check($sformatf("rv u3 no edge t%0d", t), rd[3], 32'h0);
      step();
    end

    // Random traffic against the model.
    ip = 3'b110;
    rst_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) set_reset(1'b0);
      end else if ($urandom_range(0, 599) == 0) begin
        set_reset(1'b1);
        rst_left = 2;
      end
      if ($urandom_range(0, 5) == 0) ip = 3'($urandom);
      drive(2'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom, ip);
      step();
    end
    if (reset) set_reset(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
